// File: rtl/stim_misr_pkg.sv
// Shared types and constants for the LFSR stimulus / MISR response harness.
// Holds the FSM state enum, default polynomial, LFSR taps and the response fold helper.
package stim_misr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRIVE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_STIM_W = 47;
  localparam int DEF_RESP_W = 578;
  localparam int DEF_MISR_W = 32;
  localparam int DEF_CNT_W  = 16;

  localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;

  // Right-shifting Galois form of x^64 + x^63 + x^61 + x^60 + 1.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Upper bounds for the width-generic fold helper.
  localparam int RESP_MAX = 1024;
  localparam int MISR_MAX = 64;

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return {1'b0, v[63:1]} ^ (v[0] ? LFSR_TAPS : 64'h0);
  endfunction

  // XOR of all misr_w-bit slices of resp; zero bits above the real response width
  // make the top partial slice zero-padded for free.
  function automatic logic [MISR_MAX-1:0] fold_resp(input logic [RESP_MAX-1:0] resp,
                                                    input int misr_w);
    logic [RESP_MAX-1:0] r;
    logic [MISR_MAX-1:0] mask;
    logic [MISR_MAX-1:0] acc;
    r    = resp;
    acc  = '0;
    mask = (MISR_MAX'(1) << misr_w) - MISR_MAX'(1);
    for (int s = 0; s < RESP_MAX; s += misr_w) begin
      acc = acc ^ (r[MISR_MAX-1:0] & mask);
      r   = r >> misr_w;
    end
    return acc;
  endfunction

endpackage

// File: rtl/stim_misr_if.sv
// DUT-facing bus of the harness: registered stimulus out, raw response back.
// master = harness side, slave = DUT wrapper side; no flow control on this bus.
interface stim_misr_if #(
  parameter int STIM_W = 47,
  parameter int RESP_W = 578
);
  logic [STIM_W-1:0] stim_out;
  logic              stim_valid;
  logic [RESP_W-1:0] resp_in;

  modport master (output stim_out, output stim_valid, input resp_in);
  modport slave  (input stim_out, input stim_valid, output resp_in);
endinterface

// File: rtl/misr_fold.sv
// Registered MISR: folds a wide response into MISR_W bits and shifts it into the signature.
// Latency: signature updates on the edge where en is high; clr has priority; no backpressure.
module misr_fold
  import stim_misr_pkg::*;
#(
  parameter int                RESP_W    = DEF_RESP_W,
  parameter int                MISR_W    = DEF_MISR_W,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_MAX-1:0] fold_full;
  logic [MISR_W-1:0]   fold;
  logic [MISR_W-1:0]   sig_nxt;

  assign fold_full = fold_resp(RESP_MAX'(resp), MISR_W);
  assign fold      = fold_full[MISR_W-1:0];

  generate
    if (MISR_W < MISR_MAX) begin : g_fold_hi
      logic unused_fold_hi;
      assign unused_fold_hi = ^fold_full[MISR_MAX-1:MISR_W];
    end
  endgenerate

  assign sig_nxt = {sig[MISR_W-2:0], 1'b0}
                 ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                 ^ fold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/stim_misr_harness.sv
// LFSR-driven stimulus and MISR-compacted response for cross-tool DUT comparison.
// Latency: done 2+N*(SETTLE+1) cycles after start; no backpressure, abort returns to IDLE at once.
module stim_misr_harness
  import stim_misr_pkg::*;
#(
  parameter int                STIM_W    = DEF_STIM_W,
  parameter int                RESP_W    = DEF_RESP_W,
  parameter int                MISR_W    = DEF_MISR_W,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY),
  parameter int                SETTLE    = 1,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [63:0]        seed,
  input  logic [CNT_W-1:0]   num_vec,
  stim_misr_if.master        bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   vec_cnt,
  output logic [MISR_W-1:0]  signature
);

  localparam int REPS = (STIM_W + 63) / 64;
  localparam int WCW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state;
  logic [63:0]       lfsr;
  logic [STIM_W-1:0] stim_q;
  logic              stim_vld_q;
  logic [CNT_W-1:0]  num_lat;
  logic [CNT_W-1:0]  vec_nxt;
  logic [WCW-1:0]    wait_cnt;
  logic              last_wait;
  logic              misr_clr;
  logic              misr_en;

  assign bus.stim_out   = stim_q;
  assign bus.stim_valid = stim_vld_q;

  assign last_wait = (state == WAIT) && (wait_cnt == WCW'(SETTLE - 1));
  assign vec_nxt   = vec_cnt + CNT_W'(1);
  assign misr_clr  = (state == LOAD) && !abort;
  assign misr_en   = last_wait && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= 64'h1;
      stim_q     <= '0;
      stim_vld_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vec_cnt    <= '0;
      num_lat    <= '0;
      wait_cnt   <= '0;
    end else begin
      stim_vld_q <= 1'b0;
      done       <= 1'b0;
      // Abort freezes the datapath; only the control returns to IDLE.
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= LOAD;
              busy    <= 1'b1;
              num_lat <= num_vec;
            end
          end
          LOAD: begin
            lfsr     <= (seed == 64'h0) ? 64'h1 : seed;
            vec_cnt  <= '0;
            wait_cnt <= '0;
            if (num_lat == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRIVE;
            end
          end
          DRIVE: begin
            stim_q     <= STIM_W'({REPS{lfsr}});
            stim_vld_q <= 1'b1;
            lfsr       <= lfsr_step(lfsr);
            wait_cnt   <= '0;
            state      <= WAIT;
          end
          WAIT: begin
            if (last_wait) begin
              vec_cnt <= vec_nxt;
              if (vec_nxt == num_lat) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= DRIVE;
              end
            end else begin
              wait_cnt <= wait_cnt + WCW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  misr_fold #(
    .RESP_W   (RESP_W),
    .MISR_W   (MISR_W),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (misr_clr),
    .en   (misr_en),
    .resp (bus.resp_in),
    .sig  (signature)
  );

endmodule

// File: tb/tb_stim_misr_harness.sv
// Directed bench for stim_misr_harness: a 578-bit-response instance plus a 32-bit-response one.
module tb_stim_misr_harness;

  localparam int RESP_W = 578;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] seed = 64'h0;
  logic [15:0] num_vec = 16'h0;

  logic        busy, done, busy2, done2;
  logic [15:0] vec_cnt, vec_cnt2;
  logic [31:0] signature, sig2;

  logic              resp_mode = 1'b0;
  logic [RESP_W-1:0] resp_const = '0;

  stim_misr_if #(.STIM_W(47), .RESP_W(RESP_W)) bus ();
  stim_misr_if #(.STIM_W(47), .RESP_W(32))     bus2 ();

  assign bus.resp_in  = resp_mode ? RESP_W'({13{bus.stim_out}}) : resp_const;
  assign bus2.resp_in = 32'hFFFF_FFFF;

  stim_misr_harness dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .num_vec(num_vec), .bus(bus), .busy(busy), .done(done),
    .vec_cnt(vec_cnt), .signature(signature)
  );

  stim_misr_harness #(.RESP_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .num_vec(num_vec), .bus(bus2), .busy(busy2), .done(done2),
    .vec_cnt(vec_cnt2), .signature(sig2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: Galois LFSR, replicated stimulus fed back as response, 32-bit MISR.
  task automatic model(input logic [63:0] s, input int n,
                       output logic [31:0] sg, output logic [46:0] last);
    logic [63:0]       l;
    logic [46:0]       st;
    logic [RESP_W-1:0] r;
    logic [31:0]       f;
    l    = (s == 64'h0) ? 64'h1 : s;
    sg   = 32'h0;
    last = 47'h0;
    for (int v = 0; v < n; v++) begin
      st   = l[46:0];
      last = st;
      l    = (l >> 1) ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'h0);
      r    = RESP_W'({13{st}});
      f    = 32'h0;
      for (int k = 0; k < 19; k++) begin
        f = f ^ r[31:0];
        r = r >> 32;
      end
      sg = {sg[30:0], 1'b0} ^ (sg[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
    end
  endtask

  task automatic run(input string tag, input logic [63:0] s, input logic [15:0] n,
                     input int xs, output logic [46:0] first_stim);
    int cyc;
    int vcount;
    bit seen;
    seed    = s;
    num_vec = n;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; vcount = 0; seen = 0; first_stim = '0;
    while (!seen && cyc < 2 + 2 * int'(n) + 20) begin
      @(negedge clk);
      cyc++;
      start = (cyc == xs);
      if (bus.stim_valid) begin
        if (vcount == 0) first_stim = bus.stim_out;
        vcount++;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, " done latency"}, 64'(cyc), 64'(2 + 2 * int'(n)));
    chk({tag, " stim_valid count"}, 64'(vcount), 64'(n));
    chk({tag, " busy with done"}, 64'(busy), 64'd1);
    chk({tag, " vec_cnt"}, 64'(vec_cnt), 64'(n));
    @(negedge clk);
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
    chk({tag, " idle after done"}, 64'(busy), 64'd0);
  endtask

  logic [46:0] fs;
  logic [31:0] msig;
  logic [46:0] mlast;
  int          cnt;
  int          dones;

  initial begin
    // Reset values
    #2;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst vec_cnt", 64'(vec_cnt), 64'd0);
    chk("rst signature", 64'(signature), 64'd0);
    chk("rst stim_out", 64'(bus.stim_out), 64'd0);
    chk("rst stim_valid", 64'(bus.stim_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // start and abort together in IDLE: abort wins
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    chk("start+abort busy", 64'(busy), 64'd0);

    // Empty run
    run("n0", 64'h5, 16'd0, -1, fs);
    chk("n0 signature", 64'(signature), 64'd0);

    // seed 0 maps to 1; all-ones response folds to 3 on the 578-bit instance
    resp_const = '1;
    run("n1", 64'h0, 16'd1, -1, fs);
    chk("n1 first stim", 64'(fs), 64'h1);
    chk("n1 signature", 64'(signature), 64'h3);
    chk("n1 sig 32-bit resp", 64'(sig2), 64'hFFFF_FFFF);

    run("n2", 64'h0, 16'd2, -1, fs);
    chk("n2 signature", 64'(signature), 64'h5);
    chk("n2 sig 32-bit resp", 64'(sig2), 64'h04C1_1DB6);

    // Zero response keeps the signature at zero
    resp_const = '0;
    run("n21 zero", 64'hDEAD_BEEF_0000_0001, 16'd21, -1, fs);
    chk("n21 zero signature", 64'(signature), 64'd0);

    // Stimulus-dependent response against the reference model
    resp_mode = 1'b1;
    run("n21 model", 64'h0123_4567_89AB_CDEF, 16'd21, -1, fs);
    chk("n21 model first stim", 64'(fs), 64'h4567_89AB_CDEF & 64'h7FFF_FFFF_FFFF);
    model(64'h0123_4567_89AB_CDEF, 21, msig, mlast);
    chk("n21 model signature", 64'(signature), 64'(msig));

    // Abort after five vectors
    seed    = 64'h0123_4567_89AB_CDEF;
    num_vec = 16'd21;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    while (vec_cnt != 16'd5 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort reach cycle", 64'(cnt), 64'd12);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    model(64'h0123_4567_89AB_CDEF, 5, msig, mlast);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort vec_cnt", 64'(vec_cnt), 64'd5);
    chk("abort signature", 64'(signature), 64'(msig));
    chk("abort stim_valid", 64'(bus.stim_valid), 64'd0);
    chk("abort stim_out hold", 64'(bus.stim_out), 64'(mlast));
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no done", 64'(dones), 64'd0);

    run("rerun", 64'h0123_4567_89AB_CDEF, 16'd21, -1, fs);
    model(64'h0123_4567_89AB_CDEF, 21, msig, mlast);
    chk("rerun signature", 64'(signature), 64'(msig));

    // start while busy does not disturb timing
    run("restart busy", 64'h77, 16'd3, 3, fs);

    // Async reset during WAIT of the second vector
    resp_mode  = 1'b0;
    resp_const = '1;
    seed       = 64'hA5;
    num_vec    = 16'd3;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid stim_valid", 64'(bus.stim_valid), 64'd1);
    chk("mid stim_out", 64'(bus.stim_out), 64'h52);
    chk("mid vec_cnt", 64'(vec_cnt), 64'd1);
    chk("mid signature", 64'(signature), 64'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst stim_valid", 64'(bus.stim_valid), 64'd0);
    chk("arst stim_out", 64'(bus.stim_out), 64'd0);
    chk("arst vec_cnt", 64'(vec_cnt), 64'd0);
    chk("arst signature", 64'(signature), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("arst no done", 64'(dones), 64'd0);
    chk("arst idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
